imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Serial program loader that writes the 64-word instruction memory, so programs are loaded at run time instead of being hard-coded at elaboration. It consumes a byte stream (UART RX or testbench) over a valid/ready handshake. Each frame is a length header, little-endian instruction words, then an XOR checksum. The block issues one-cycle write strobes to the instruction memory write port and holds the CPU while a load is in progress or after a failed load.

Parameters:
ADDR_W, 6, instruction memory word-address width
DEPTH, 64, number of instruction words; maximum frame length
TIMEOUT_CYC, 1000000, idle cycles allowed between accepted bytes while loading; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data is valid
rx_ready  out  1  loader accepts a byte; a transfer occurs on the clock edge where rx_valid and rx_ready are both 1
wr_en  out  1  instruction memory write strobe, one cycle per word
wr_addr  out  ADDR_W  word address being written
wr_data  out  32  assembled instruction word
busy  out  1  high in LEN, DATA and CSUM
cpu_hold  out  1  high while busy or in ERR; the core is stalled or held in reset while this is high
done  out  1  sticky: last load completed and its checksum matched
error  out  1  sticky: last load failed
words_loaded  out  ADDR_W+1  words written in the current or last load

Behaviour:
- Interface: one clock domain (clk); rst is asynchronous and active-high.
- Reset:
  - State returns to IDLE immediately.
  - All outputs are 0, including wr_en, rx_ready, cpu_hold and words_loaded.
  - Internal byte index, word index, checksum and timeout counter clear.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR. All outputs are registered except rx_ready, which is decoded from state (1 in LEN, DATA and CSUM, otherwise 0).
- IDLE / DONE / ERR, on start:
  - Clear done, error, words_loaded, checksum and indices.
  - Go to LEN.
  - start in any other state is ignored.
- LEN, on byte b:
  - N = (b==0) ? DEPTH : b.
  - If b > DEPTH, go to ERR.
  - Otherwise checksum ^= b and go to DATA.
- DATA, byte assembly:
  - Byte k (k = 0..3) of a word goes to bits [8k+7:8k], so the least-significant byte comes first.
  - Every accepted byte updates checksum ^= byte.
- DATA, word write:
  - On the edge that accepts byte 3, wr_en, wr_addr (word index) and wr_data (completed word) are registered.
  - wr_en is high for exactly the following cycle.
  - words_loaded increments on the same edge.
  - rx_ready stays 1; a write never stalls the stream, and back-to-back words give wr_en pulses 4 cycles apart at minimum.
- DATA, exit: after word N-1 is accepted, go to CSUM.
- CSUM, on byte c:
  - If c equals the running checksum (XOR of the length byte and all data bytes), go to DONE with done=1.
  - Otherwise go to ERR with error=1.
  - Words already written are not rolled back.
- Timeout:
  - The counter clears on every accepted byte and on state entry, and counts while in LEN, DATA or CSUM.
  - When the count reaches TIMEOUT_CYC, go to ERR.
- Output values by state:
  - DONE: done=1, cpu_hold=0, busy=0.
  - ERR: error=1, cpu_hold=1, busy=0.
  - done and error are never both 1.
- rx_valid while rx_ready is 0 is ignored; no byte is consumed.
- Reset mid-load: the load aborts. Memory contents already written remain; a new start performs a clean reload from address 0.
- wr_addr never exceeds DEPTH-1; there is no wrap-around because N ≤ DEPTH is enforced in LEN.

Test Plan:
1. Two-word load, no gaps: start; bytes 02, 13 00 10 00, 83 20 00 00, A2.
   - wr_en pulses at addr 0 with 0x00100013, then addr 1 with 0x00002083.
   - Then done=1, error=0, cpu_hold=0, words_loaded=2, rx_ready=0.
2. Bad checksum: same frame with the final byte A3.
   - Both writes still occur.
   - error=1, done=0, cpu_hold=1.
   - A following start clears error and reloads successfully.
3. Oversized length: header 0x41.
   - ERR on the next cycle, error=1, no wr_en ever asserted.
4. Backpressure and timeout (TIMEOUT_CYC=16):
   - Frame 1 with random 0–10-cycle rx_valid gaps: results identical to test 1.
   - Separately, stall 16 cycles after two data bytes: error=1, no wr_en.
5. Full memory: header 0x00 followed by 256 bytes with value = word index.
   - 64 writes at addresses 0..63 with wr_data={4{idx}}.
   - words_loaded=64, done=1 with the correct checksum.
6. Reset mid-load: assert rst during the DATA state of the second word.
   - All outputs are 0 in the same cycle, without waiting for a clock edge.
   - After release, start plus the frame from test 1 loads cleanly (done=1).
7. Start while busy: a start pulse during DATA has no effect on the state, indices or checksum.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
//   rx_data  [7:0]       incoming byte
//   rx_valid             rx_data is valid
//   rx_ready             loader accepts a byte (transfer when valid && ready)
//   wr_en                one-cycle instruction memory write strobe
//   wr_addr  [ADDR_W-1:0] word address being written
//   wr_data  [31:0]      assembled instruction word
// slave  : the loader side (consumes bytes, drives the memory write port)
// master : the environment side (byte source, memory write sink)
`timescale 1ns/1ps
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Serial program loader for the instruction memory.
// Frame: length byte (0 means DEPTH), N little-endian 32-bit words, XOR checksum
// over the length byte and all data bytes.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle pulse, begins a load from IDLE, DONE or ERR
//   bus           imem_loader_if.slave: byte stream in, memory write port out
//   busy          high in LEN, DATA, CSUM
//   cpu_hold      high while busy or in ERR
//   done, error   sticky result of the last load
//   words_loaded  words written in the current or last load
`timescale 1ns/1ps
module imem_loader #(
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 64,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            busy,
  output logic            cpu_hold,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam int              LW       = ADDR_W + 1;
  localparam logic [8:0]      DEPTH_B  = 9'(DEPTH);
  localparam logic [LW-1:0]   DEPTH_W  = LW'(DEPTH);
  localparam logic [31:0]     TMO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam bit              TMO_EN   = (TIMEOUT_CYC != 0);

  state_t        state;
  logic [LW-1:0] n_words;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic [7:0]    csum;
  logic [31:0]   tmo_cnt;
  logic          xfer;
  logic          tmo_hit;
  logic [LW-1:0] words_next;

  // rx_ready is the only output decoded straight from state
  assign bus.rx_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign xfer         = bus.rx_valid && bus.rx_ready;
  assign words_next   = words_loaded + LW'(1);
  // An accepted byte in the same cycle always wins over the timeout
  assign tmo_hit      = TMO_EN && bus.rx_ready && !xfer && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      n_words      <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      csum         <= '0;
      tmo_cnt      <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      busy         <= 1'b0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      // Idle-gap counter: held at zero outside the loading states, so every
      // state entry starts from zero as well
      if (xfer || !bus.rx_ready) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 32'd1;

      if (tmo_hit) begin
        state <= S_ERR;
        busy  <= 1'b0;
        error <= 1'b1;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
              state        <= S_LEN;
              busy         <= 1'b1;
              cpu_hold     <= 1'b1;
              done         <= 1'b0;
              error        <= 1'b0;
              words_loaded <= '0;
              csum         <= '0;
              byte_idx     <= '0;
              n_words      <= '0;
            end
          end
          S_LEN: begin
            if (xfer) begin
              if ({1'b0, bus.rx_data} > DEPTH_B) begin
                state <= S_ERR;
                busy  <= 1'b0;
                error <= 1'b1;
              end else begin
                n_words <= (bus.rx_data == 8'd0) ? DEPTH_W : LW'(bus.rx_data);
                csum    <= csum ^ bus.rx_data;
                state   <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (xfer) begin
              csum     <= csum ^ bus.rx_data;
              byte_idx <= byte_idx + 2'd1;
              case (byte_idx)
                2'd0:    word_buf[7:0]   <= bus.rx_data;
                2'd1:    word_buf[15:8]  <= bus.rx_data;
                2'd2:    word_buf[23:16] <= bus.rx_data;
                default: begin
                  // Last byte of a word: the write goes out next cycle while
                  // the stream keeps flowing
                  bus.wr_en    <= 1'b1;
                  bus.wr_addr  <= words_loaded[ADDR_W-1:0];
                  bus.wr_data  <= {bus.rx_data, word_buf};
                  words_loaded <= words_next;
                  if (words_next == n_words) state <= S_CSUM;
                end
              endcase
            end
          end
          S_CSUM: begin
            if (xfer) begin
              busy <= 1'b0;
              if (bus.rx_data == csum) begin
                state    <= S_DONE;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
              end else begin
                state <= S_ERR;
                error <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int ADDR_W = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy, cpu_hold, done, error;
  logic [ADDR_W:0] words_loaded;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(64), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Write-port monitor
  int              wr_count = 0;
  int              cyc = 0;
  logic [ADDR_W-1:0] log_addr [256];
  logic [31:0]     log_data [256];
  int              log_cyc  [256];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.wr_en && wr_count < 256) begin
      log_addr[wr_count] <= bus.wr_addr;
      log_data[wr_count] <= bus.wr_data;
      log_cyc[wr_count]  <= cyc;
      wr_count           <= wr_count + 1;
    end
  end

  logic [7:0] frame1 [9] = '{8'h02, 8'h13, 8'h00, 8'h10, 8'h00, 8'h83, 8'h20, 8'h00, 8'h00};
  int         gaps   [10] = '{0, 3, 10, 1, 7, 0, 5, 2, 9, 4};

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (!bus.rx_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.rx_ready) begin
      failures++;
      $display("FAIL send_byte: rx_ready=%0b required 1 for byte %h", bus.rx_ready, b);
    end else begin
      @(posedge clk);
    end
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_frame1(input logic [7:0] last, input bit gapped);
    for (int i = 0; i < 9; i++) send_byte(frame1[i], gapped ? gaps[i] : 0);
    send_byte(last, gapped ? gaps[9] : 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.wr_en, bus.rx_ready, busy, cpu_hold, done, error} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 000000",
               {bus.wr_en, bus.rx_ready, busy, cpu_hold, done, error});
    end
    checks++;
    if (words_loaded !== '0) begin
      failures++;
      $display("FAIL reset_words: got %0d required 0", words_loaded);
    end
    checks++;
    if (bus.wr_addr !== '0 || bus.wr_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_wr: got addr=%0d data=%h required 0/0", bus.wr_addr, bus.wr_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_two_word();
    int base;
    base = wr_count;
    pulse_start();
    #1;
    checks++;
    if ({busy, cpu_hold, bus.rx_ready, done, error} !== 5'b11100) begin
      failures++;
      $display("FAIL tw_loading_flags: got %b required 11100",
               {busy, cpu_hold, bus.rx_ready, done, error});
    end
    send_frame1(8'hA2, 1'b0);
    @(negedge clk); #1;
    checks++;
    if (wr_count - base !== 2) begin
      failures++;
      $display("FAIL tw_writes: got %0d required 2", wr_count - base);
    end
    checks++;
    if (log_addr[base] !== 6'd0 || log_data[base] !== 32'h00100013) begin
      failures++;
      $display("FAIL tw_word0: got addr=%0d data=%h required 0/00100013", log_addr[base], log_data[base]);
    end
    checks++;
    if (log_addr[base+1] !== 6'd1 || log_data[base+1] !== 32'h00002083) begin
      failures++;
      $display("FAIL tw_word1: got addr=%0d data=%h required 1/00002083", log_addr[base+1], log_data[base+1]);
    end
    checks++;
    if (log_cyc[base+1] - log_cyc[base] !== 4) begin
      failures++;
      $display("FAIL tw_spacing: got %0d required 4", log_cyc[base+1] - log_cyc[base]);
    end
    checks++;
    if ({done, error, cpu_hold, busy, bus.rx_ready} !== 5'b10000) begin
      failures++;
      $display("FAIL tw_done_flags: got %b required 10000",
               {done, error, cpu_hold, busy, bus.rx_ready});
    end
    checks++;
    if (words_loaded !== 7'd2) begin
      failures++;
      $display("FAIL tw_words: got %0d required 2", words_loaded);
    end
  endtask

  task automatic test_bad_csum();
    int base;
    base = wr_count;
    pulse_start();
    send_frame1(8'hA3, 1'b0);
    @(negedge clk); #1;
    checks++;
    if (wr_count - base !== 2) begin
      failures++;
      $display("FAIL bc_writes: got %0d required 2", wr_count - base);
    end
    checks++;
    if ({error, done, cpu_hold, busy} !== 4'b1010) begin
      failures++;
      $display("FAIL bc_flags: got %b required 1010", {error, done, cpu_hold, busy});
    end
    pulse_start();
    #1;
    checks++;
    if ({error, busy, cpu_hold} !== 3'b011) begin
      failures++;
      $display("FAIL bc_restart_flags: got %b required 011", {error, busy, cpu_hold});
    end
    send_frame1(8'hA2, 1'b0);
    @(negedge clk); #1;
    checks++;
    if ({done, error, cpu_hold} !== 3'b100 || words_loaded !== 7'd2) begin
      failures++;
      $display("FAIL bc_reload: got flags=%b words=%0d required 100/2",
               {done, error, cpu_hold}, words_loaded);
    end
  endtask

  task automatic test_oversize();
    int base;
    base = wr_count;
    pulse_start();
    send_byte(8'h41, 0);
    @(negedge clk); #1;
    checks++;
    if ({error, done, cpu_hold, busy, bus.rx_ready} !== 5'b10100) begin
      failures++;
      $display("FAIL ov_flags: got %b required 10100",
               {error, done, cpu_hold, busy, bus.rx_ready});
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (wr_count - base !== 0) begin
      failures++;
      $display("FAIL ov_writes: got %0d required 0", wr_count - base);
    end
  endtask

  task automatic test_gaps();
    int base;
    base = wr_count;
    pulse_start();
    send_frame1(8'hA2, 1'b1);
    @(negedge clk); #1;
    checks++;
    if (wr_count - base !== 2 || log_data[base] !== 32'h00100013 || log_data[base+1] !== 32'h00002083
        || log_addr[base+1] !== 6'd1) begin
      failures++;
      $display("FAIL gap_writes: got n=%0d d0=%h d1=%h a1=%0d required 2/00100013/00002083/1",
               wr_count - base, log_data[base], log_data[base+1], log_addr[base+1]);
    end
    checks++;
    if ({done, error, cpu_hold} !== 3'b100 || words_loaded !== 7'd2) begin
      failures++;
      $display("FAIL gap_flags: got flags=%b words=%0d required 100/2", {done, error, cpu_hold}, words_loaded);
    end
  endtask

  task automatic test_timeout();
    int base;
    base = wr_count;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    repeat (16) @(negedge clk);
    #1;
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL to_early: got error=%0b busy=%0b required 0/1", error, busy);
    end
    @(negedge clk); #1;
    checks++;
    if ({error, done, cpu_hold, busy} !== 4'b1010) begin
      failures++;
      $display("FAIL to_flags: got %b required 1010", {error, done, cpu_hold, busy});
    end
    checks++;
    if (wr_count - base !== 0) begin
      failures++;
      $display("FAIL to_writes: got %0d required 0", wr_count - base);
    end
  endtask

  task automatic test_full();
    int base;
    base = wr_count;
    pulse_start();
    send_byte(8'h00, 0);
    for (int w = 0; w < 64; w++)
      for (int k = 0; k < 4; k++) send_byte(8'(w), 0);
    // Each word contributes w^w^w^w = 0, header is 0
    send_byte(8'h00, 0);
    @(negedge clk); #1;
    checks++;
    if (wr_count - base !== 64) begin
      failures++;
      $display("FAIL full_writes: got %0d required 64", wr_count - base);
    end
    for (int w = 0; w < 64; w++) begin
      logic [7:0] b;
      b = 8'(w);
      checks++;
      if (log_addr[base+w] !== 6'(w) || log_data[base+w] !== {4{b}}) begin
        failures++;
        $display("FAIL full_word%0d: got addr=%0d data=%h required %0d/%h",
                 w, log_addr[base+w], log_data[base+w], w, {4{b}});
      end
    end
    checks++;
    if ({done, error} !== 2'b10 || words_loaded !== 7'd64) begin
      failures++;
      $display("FAIL full_flags: got flags=%b words=%0d required 10/64", {done, error}, words_loaded);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(frame1[i], 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.wr_en, bus.rx_ready, busy, cpu_hold, done, error} !== 6'b0) begin
      failures++;
      $display("FAIL rm_flags: got %b required 000000",
               {bus.wr_en, bus.rx_ready, busy, cpu_hold, done, error});
    end
    checks++;
    if (words_loaded !== '0 || bus.wr_data !== 32'h0 || bus.wr_addr !== '0) begin
      failures++;
      $display("FAIL rm_regs: got words=%0d data=%h addr=%0d required 0/0/0",
               words_loaded, bus.wr_data, bus.wr_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    base = wr_count;
    pulse_start();
    send_frame1(8'hA2, 1'b0);
    @(negedge clk); #1;
    checks++;
    if ({done, error} !== 2'b10 || wr_count - base !== 2 || log_addr[base] !== 6'd0
        || log_data[base] !== 32'h00100013) begin
      failures++;
      $display("FAIL rm_reload: got flags=%b n=%0d a0=%0d d0=%h required 10/2/0/00100013",
               {done, error}, wr_count - base, log_addr[base], log_data[base]);
    end
  endtask

  task automatic test_start_busy();
    int base;
    base = wr_count;
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(frame1[i], 0);
    pulse_start();
    for (int i = 3; i < 9; i++) send_byte(frame1[i], 0);
    send_byte(8'hA2, 0);
    @(negedge clk); #1;
    checks++;
    if (wr_count - base !== 2 || log_data[base] !== 32'h00100013 || log_data[base+1] !== 32'h00002083) begin
      failures++;
      $display("FAIL sb_writes: got n=%0d d0=%h d1=%h required 2/00100013/00002083",
               wr_count - base, log_data[base], log_data[base+1]);
    end
    checks++;
    if ({done, error} !== 2'b10 || words_loaded !== 7'd2) begin
      failures++;
      $display("FAIL sb_flags: got flags=%b words=%0d required 10/2", {done, error}, words_loaded);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_two_word();
    test_bad_csum();
    test_oversize();
    test_gaps();
    test_timeout();
    test_full();
    test_reset_mid();
    test_start_busy();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
